// File: rtl/rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// Module   : rx_unstuff_shift
// Purpose  : USB 1.1 receive stage after the NRZI decoder. Strips stuffed
//            zeros, flags bit-stuff violations and assembles the remaining
//            bits LSB-first into bytes for the RX control FSM / FIFO.
// Ports    : clk           - system clock, rising edge
//            n_rst         - asynchronous reset, active-low
//            shift_enable  - one-cycle strobe, d_orig holds a valid bit
//            d_orig        - NRZI-decoded bit
//            eop           - end-of-packet (SE0) level
//            clear         - synchronous restart at packet start
//            rcv_data      - last assembled byte, LSB = first bit on the wire
//            byte_received - one-cycle pulse, rcv_data holds a new byte
//            stuff_error   - one-cycle pulse, stuff-bit violation seen
// Revision : 1.0 - initial release
// ============================================================================
module rx_unstuff_shift #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              shift_enable,
  input  logic              d_orig,
  input  logic              eop,
  input  logic              clear,
  output logic [DATA_W-1:0] rcv_data,
  output logic              byte_received,
  output logic              stuff_error
);

  localparam int c_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int c_OW = $clog2(STUFF_LEN + 1);

  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);
  localparam logic [c_OW-1:0] c_ONES_MAX = c_OW'(STUFF_LEN);

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_STUFF = 2'd1;
  localparam logic [1:0] c_ST_EOP   = 2'd2;

  logic [1:0]        r_state;
  logic [c_BW-1:0]   r_bit_cnt;
  logic [c_OW-1:0]   r_ones_cnt;
  logic [DATA_W-1:0] r_rcv_data;
  logic              r_byte_received;
  logic              r_stuff_error;

  logic [1:0]        w_state_nxt;
  logic [c_BW-1:0]   w_bit_cnt_nxt;
  logic [c_OW-1:0]   w_ones_cnt_nxt;
  logic [c_OW-1:0]   w_ones_inc;
  logic              w_accept;
  logic              w_byte_done;
  logic              w_stuff_err;

  assign w_ones_inc = r_ones_cnt + c_OW'(1);

  // A data bit is shifted only in RUN and only when neither restart nor
  // end-of-packet takes priority in the same cycle.
  assign w_accept = (r_state == c_ST_RUN) && shift_enable && !eop && !clear;

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_ones_cnt_nxt = r_ones_cnt;
    w_byte_done    = 1'b0;
    w_stuff_err    = 1'b0;

    if (clear) begin
      w_state_nxt    = c_ST_RUN;
      w_bit_cnt_nxt  = '0;
      w_ones_cnt_nxt = '0;
    end else if (eop) begin
      // Partial byte is dropped silently; counters restart for next packet.
      w_state_nxt    = c_ST_EOP;
      w_bit_cnt_nxt  = '0;
      w_ones_cnt_nxt = '0;
    end else begin
      case (r_state)
        c_ST_RUN: begin
          if (shift_enable) begin
            if (d_orig) begin
              w_ones_cnt_nxt = w_ones_inc;
              if (w_ones_inc == c_ONES_MAX) begin
                w_state_nxt = c_ST_STUFF;
              end
            end else begin
              w_ones_cnt_nxt = '0;
            end
            // The ones run deliberately survives a byte boundary.
            if (r_bit_cnt == c_BIT_LAST) begin
              w_bit_cnt_nxt = '0;
              w_byte_done   = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + c_BW'(1);
            end
          end
        end
        c_ST_STUFF: begin
          // Stuff bit: never shifted, never counted; must be a zero.
          if (shift_enable) begin
            w_ones_cnt_nxt = '0;
            w_state_nxt    = c_ST_RUN;
            w_stuff_err    = d_orig;
          end
        end
        c_ST_EOP: begin
          w_state_nxt = c_ST_RUN;
        end
        default: begin
          w_state_nxt    = c_ST_RUN;
          w_bit_cnt_nxt  = '0;
          w_ones_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= c_ST_RUN;
      r_bit_cnt       <= '0;
      r_ones_cnt      <= '0;
      r_rcv_data      <= '0;
      r_byte_received <= 1'b0;
      r_stuff_error   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_ones_cnt      <= w_ones_cnt_nxt;
      r_byte_received <= w_byte_done;
      r_stuff_error   <= w_stuff_err;
      if (w_accept) begin
        r_rcv_data <= {d_orig, r_rcv_data[DATA_W-1:1]};
      end
    end
  end

  assign rcv_data      = r_rcv_data;
  assign byte_received = r_byte_received;
  assign stuff_error   = r_stuff_error;

endmodule
`default_nettype wire

// File: tb/tb_rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_unstuff_shift
// Purpose  : Self-checking bench for rx_unstuff_shift. A packet-level model
//            predicts every byte and stuff-error pulse (value and cycle) into
//            queues; a monitor pops and compares whenever the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       shift_enable = 1'b0;
  logic       d_orig = 1'b0;
  logic       eop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       stuff_error;

  rx_unstuff_shift #(.DATA_W(8), .STUFF_LEN(6)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .clear        (clear),
    .rcv_data     (rcv_data),
    .byte_received(byte_received),
    .stuff_error  (stuff_error)
  );

  always #5 clk = ~clk;

  int cycnt = 0;
  always @(posedge clk) cycnt <= cycnt + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } byte_t;

  byte_t exp_bytes[$];
  int    exp_errs[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: bits collected so far, length of current run of
  // data ones, whether the next bit is a stuff bit, whether inside EOP.
  bit m_bits[$];
  int m_run;
  bit m_stuff_next;
  bit m_in_eop;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_bits.delete();
    m_run        = 0;
    m_stuff_next = 0;
    m_in_eop     = 0;
  endfunction

  function automatic void model_step(bit s, bit dd, bit e, bit c);
    logic [7:0] b;
    if (c) begin
      model_reset();
    end else if (e) begin
      model_reset();
      m_in_eop = 1;
    end else if (m_in_eop) begin
      m_in_eop = 0;
    end else if (s) begin
      if (m_stuff_next) begin
        m_stuff_next = 0;
        m_run        = 0;
        if (dd) exp_errs.push_back(cycnt + 1);
      end else begin
        m_bits.push_back(dd);
        m_run = dd ? m_run + 1 : 0;
        if (m_run == 6) m_stuff_next = 1;
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) b[i] = m_bits[i];
          exp_bytes.push_back('{data: b, cyc: cycnt + 1});
          m_bits.delete();
        end
      end
    end
  endfunction

  task automatic step(input bit s, input bit dd, input bit e, input bit c);
    model_step(s, dd, e, c);
    shift_enable = s;
    d_orig       = dd;
    eop          = e;
    clear        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic monitor();
    byte_t x;
    int    ec;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (byte_received) begin
          if (exp_bytes.size() == 0) begin
            check("unexpected_byte_pulse", 32'd1, 32'd0);
          end else begin
            x = exp_bytes.pop_front();
            check("byte_data", {24'd0, rcv_data}, {24'd0, x.data});
            check("byte_cycle", cycnt, x.cyc);
          end
        end
        if (stuff_error) begin
          if (exp_errs.size() == 0) begin
            check("unexpected_stuff_error", 32'd1, 32'd0);
          end else begin
            ec = exp_errs.pop_front();
            check("stuff_err_cycle", cycnt, ec);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    fork
      monitor();
    join_none

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_rcv_data", {24'd0, rcv_data}, 32'h0);
    check("reset_byte_received", {31'd0, byte_received}, 32'd0);
    check("reset_stuff_error", {31'd0, stuff_error}, 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Plain byte
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h000000A5, 8);
    check("t1_rcv_data", {24'd0, rcv_data}, 32'hA5);

    // Stuffed zero removed
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h0000013F, 9);
    check("t2_rcv_data", {24'd0, rcv_data}, 32'hBF);

    // Seventh one is a stuff violation and is dropped
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h0000007F, 9);
    check("t3_rcv_data", {24'd0, rcv_data}, 32'h3F);

    // Stuff run spanning the byte boundary
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h000000FC, 17);
    check("t4_rcv_data", {24'd0, rcv_data}, 32'h00);

    // EOP discards the partial byte
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h00000005, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000003C, 8);
    check("t5_rcv_data", {24'd0, rcv_data}, 32'h3C);

    // Reset mid-byte, then clear with a same-cycle bit
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("t6_rst_rcv_data", {24'd0, rcv_data}, 32'h0);
    check("t6_rst_byte_received", {31'd0, byte_received}, 32'd0);
    check("t6_rst_stuff_error", {31'd0, stuff_error}, 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(32'h00000096, 8);
    check("t6_rcv_data", {24'd0, rcv_data}, 32'h96);

    // Randomized traffic, biased towards ones to exercise stuffing
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    check("bytes_outstanding", exp_bytes.size(), 32'd0);
    check("stuff_errs_outstanding", exp_errs.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
